ysyx_22040088_pcctrl: RTL and testbench

Multi-cycle PC sequencer for the single-issue NPC core. It owns the architectural PC register and issues instruction fetches over a valid/ready port. It hands each fetched instruction to decode/execute, then commits the next PC chosen from the branch-unit candidate targets. It also detects misaligned targets, handles halt (ebreak), and counts retired instructions.

---
 rtl/ysyx_22040088_pcctrl_if.sv | 30 +++
 rtl/ysyx_22040088_pcctrl.sv | 135 +++++++++++++
 tb/tb_ysyx_22040088_pcctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040088_pcctrl_if.sv
// Instruction-fetch channel between the PC sequencer (master) and imem (slave):
// a request carrying the fetch address, then a response carrying the 32-bit word.
interface ysyx_22040088_pcctrl_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_req_addr;
    logic            if_resp_valid;
    logic            if_resp_ready;
    logic [31:0]     if_resp_inst;

    modport master (
        output if_req_valid,
        output if_req_addr,
        output if_resp_ready,
        input  if_req_ready,
        input  if_resp_valid,
        input  if_resp_inst
    );

    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        input  if_resp_ready,
        output if_req_ready,
        output if_resp_valid,
        output if_resp_inst
    );
endinterface

// File: rtl/ysyx_22040088_pcctrl.sv
// Multi-cycle PC sequencer: owns the architectural PC, fetches over the imem channel, issues to
// execute, then commits the branch-selected next PC, trapping on misaligned targets.
module ysyx_22040088_pcctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22040088_pcctrl_if.master imem,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [31:0]            id_inst,
    output logic [XLEN-1:0]        id_pc,
    input  logic                   ex_done,
    input  logic                   ex_halt,
    input  logic [2:0]             ex_br_sel,
    input  logic [XLEN-1:0]        pcadd,
    input  logic [XLEN-1:0]        jalpc,
    input  logic [XLEN-1:0]        jalrpc,
    input  logic [XLEN-1:0]        beqpc,
    input  logic [XLEN-1:0]        bnepc,
    input  logic [XLEN-1:0]        bltpc,
    input  logic [XLEN-1:0]        bgepc,
    output logic [XLEN-1:0]        pc,
    output logic                   halted,
    output logic                   trap,
    output logic [XLEN-1:0]        trap_pc,
    output logic [63:0]            retired
);

    typedef enum logic [2:0] {
        StFetchReq,
        StFetchWait,
        StIssue,
        StExec,
        StHalt,
        StTrap
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic [63:0]     retired_q, retired_d;
    logic [XLEN-1:0] npc;

    // Codes 0 and 7 (reserved) both fall through to the sequential target.
    always_comb begin
        npc = pcadd;
        case (ex_br_sel)
            3'd1:    npc = jalpc;
            3'd2:    npc = jalrpc;
            3'd3:    npc = beqpc;
            3'd4:    npc = bnepc;
            3'd5:    npc = bltpc;
            3'd6:    npc = bgepc;
            default: npc = pcadd;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        trap_pc_d = trap_pc_q;
        retired_d = retired_q;
        unique case (state_q)
            StFetchReq: begin
                if (imem.if_req_ready) state_d = StFetchWait;
            end
            StFetchWait: begin
                if (imem.if_resp_valid) begin
                    id_inst_d = imem.if_resp_inst;
                    id_pc_d   = pc_q;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (id_ready) state_d = StExec;
            end
            StExec: begin
                // Halt outranks the alignment check: ebreak retires even with a bad target.
                if (ex_done) begin
                    if (ex_halt) begin
                        retired_d = retired_q + 64'd1;
                        state_d   = StHalt;
                    end else if (npc[1:0] != 2'b00) begin
                        trap_pc_d = npc;
                        state_d   = StTrap;
                    end else begin
                        pc_d      = npc;
                        retired_d = retired_q + 64'd1;
                        state_d   = StFetchReq;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetchReq;
            pc_q      <= RESET_PC;
            id_pc_q   <= '0;
            id_inst_q <= '0;
            trap_pc_q <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            trap_pc_q <= trap_pc_d;
            retired_q <= retired_d;
        end
    end

    assign imem.if_req_valid  = (state_q == StFetchReq);
    assign imem.if_req_addr   = pc_q;
    assign imem.if_resp_ready = (state_q == StFetchWait);
    assign id_valid           = (state_q == StIssue);
    assign id_inst            = id_inst_q;
    assign id_pc              = id_pc_q;
    assign pc                 = pc_q;
    assign halted             = (state_q == StHalt);
    assign trap               = (state_q == StTrap);
    assign trap_pc            = trap_pc_q;
    assign retired            = retired_q;

endmodule

// File: tb/tb_ysyx_22040088_pcctrl.sv
// Bench for ysyx_22040088_pcctrl: directed vector table, hand-written reset/halt sequences and
// randomized instruction streams checked against an architectural model.
module tb_ysyx_22040088_pcctrl;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        ex_done, ex_halt;
    logic [2:0]  ex_br_sel;
    logic [63:0] cand [8];
    logic [63:0] pc, trap_pc, retired;
    logic        halted, trap;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    // Architectural model: what the programmer sees after each commit.
    logic [63:0] m_pc, m_ret, m_trap_pc;
    logic        m_halt, m_trap;

    ysyx_22040088_pcctrl_if #(.XLEN(64)) imem ();

    ysyx_22040088_pcctrl #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .ex_done   (ex_done),
        .ex_halt   (ex_halt),
        .ex_br_sel (ex_br_sel),
        .pcadd     (cand[0]),
        .jalpc     (cand[1]),
        .jalrpc    (cand[2]),
        .beqpc     (cand[3]),
        .bnepc     (cand[4]),
        .bltpc     (cand[5]),
        .bgepc     (cand[6]),
        .pc        (pc),
        .halted    (halted),
        .trap      (trap),
        .trap_pc   (trap_pc),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so both sides are stable at negedge.
    always @(negedge clk) begin
        if (!rst && imem.if_req_valid && imem.if_req_ready) hs_cnt++;
    end

    typedef struct {
        logic [2:0]  sel;
        logic        halt;
        logic [63:0] pcadd;
        logic [63:0] tgt;
        int          rq;
        int          rs;
        logic [63:0] e_pc;
        logic [63:0] e_ret;
        logic        e_trap;
        logic [63:0] e_tpc;
    } vec_t;

    vec_t tbl [8];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hsv();
        return {61'd0, imem.if_req_valid, imem.if_resp_ready, id_valid};
    endfunction

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".retired"}, retired, m_ret);
        chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
        chk({tag, ".trap"}, 64'(trap), 64'(m_trap));
        chk({tag, ".trap_pc"}, trap_pc, m_trap_pc);
    endtask

    task automatic noise(input bit en);
        ex_done   = en ? 1'($urandom) : 1'b0;
        ex_halt   = en ? 1'($urandom) : 1'b0;
        ex_br_sel = 3'($urandom);
    endtask

    task automatic set_cands(input logic [2:0] sel, input logic [63:0] pa, input logic [63:0] tgt);
        for (int k = 1; k < 8; k++) cand[k] = 64'h9000_0000 + 64'(k * 256);
        cand[0] = pa;
        if (sel != 3'd0) cand[sel] = tgt;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        imem.if_req_ready  = 1'b0;
        imem.if_resp_valid = 1'b0;
        imem.if_resp_inst  = '0;
        id_ready = 1'b0;
        noise(1'b0);
        repeat (n) cycle();
        m_pc = RST_PC; m_ret = '0; m_halt = 1'b0; m_trap = 1'b0; m_trap_pc = '0;
        chk_arch("reset");
        chk("reset.id_inst", 64'(id_inst), 64'd0);
        chk("reset.id_pc", id_pc, 64'd0);
        chk("reset.hs", hsv(), 64'd4);
        rst = 1'b0;
    endtask

    task automatic do_instr(input int rq, input int rs, input int isd, input int exd, input bit nz,
                            input logic [31:0] word, input logic [2:0] sel, input logic halt);
        logic [63:0] npc;
        int          hs0;
        hs0 = hs_cnt;
        for (int i = 0; i < rq; i++) begin
            chk("req_stall.hs", hsv(), 64'd4);
            chk("req_stall.addr", imem.if_req_addr, m_pc);
            imem.if_req_ready = 1'b0;
            noise(nz);
            cycle();
        end
        chk("req.hs", hsv(), 64'd4);
        chk("req.addr", imem.if_req_addr, m_pc);
        imem.if_req_ready = 1'b1;
        noise(nz);
        cycle();
        imem.if_req_ready = 1'b0;
        for (int i = 0; i < rs; i++) begin
            chk("wait_stall.hs", hsv(), 64'd2);
            imem.if_resp_inst = $urandom;
            noise(nz);
            cycle();
        end
        chk("wait.hs", hsv(), 64'd2);
        imem.if_resp_valid = 1'b1;
        imem.if_resp_inst  = word;
        cycle();
        imem.if_resp_valid = 1'b0;
        imem.if_resp_inst  = $urandom;
        for (int i = 0; i <= isd; i++) begin
            chk("issue.hs", hsv(), 64'd1);
            chk("issue.id_inst", 64'(id_inst), 64'(word));
            chk("issue.id_pc", id_pc, m_pc);
            id_ready = (i == isd);
            noise(nz);
            cycle();
        end
        id_ready = 1'b0;
        noise(1'b0);
        for (int i = 0; i < exd; i++) begin
            chk("exec.hs", hsv(), 64'd0);
            chk("exec.id_inst", 64'(id_inst), 64'(word));
            chk("exec.pc", pc, m_pc);
            cycle();
        end
        ex_br_sel = sel;
        ex_halt   = halt;
        ex_done   = 1'b1;
        cycle();
        ex_done = 1'b0;
        ex_halt = 1'b0;
        npc = (sel == 3'd7) ? cand[0] : cand[sel];
        if (halt) begin
            m_ret++;
            m_halt = 1'b1;
        end else if (npc[1:0] != 2'b00) begin
            m_trap = 1'b1;
            m_trap_pc = npc;
        end else begin
            m_pc = npc;
            m_ret++;
        end
        chk("fetch_once", 64'(hs_cnt - hs0), 64'd1);
        chk_arch("commit");
        if (m_halt || m_trap) begin
            chk("term.hs", hsv(), 64'd0);
        end else begin
            chk("next.hs", hsv(), 64'd4);
            chk("next.addr", imem.if_req_addr, m_pc);
        end
    endtask

    task automatic idle_terminal(input int n);
        for (int i = 0; i < n; i++) begin
            imem.if_req_ready  = 1'($urandom);
            imem.if_resp_valid = 1'b0;
            id_ready = 1'($urandom);
            noise(1'b1);
            cycle();
            chk("terminal.hs", hsv(), 64'd0);
            chk_arch("terminal");
        end
        imem.if_req_ready = 1'b0;
        id_ready = 1'b0;
        noise(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 8; k++) cand[k] = '0;
        tbl[0] = '{3'd0, 1'b0, 64'h8000_0004, 64'h0, 0, 0, 64'h8000_0004, 64'd1, 1'b0, 64'd0};
        tbl[1] = '{3'd1, 1'b0, 64'h8000_0008, 64'h8000_0100, 5, 3, 64'h8000_0100, 64'd2, 1'b0,
                   64'd0};
        tbl[2] = '{3'd2, 1'b0, 64'h8000_0104, 64'h8000_0200, 1, 0, 64'h8000_0200, 64'd3, 1'b0,
                   64'd0};
        tbl[3] = '{3'd3, 1'b0, 64'h8000_0204, 64'h8000_0010, 0, 2, 64'h8000_0010, 64'd4, 1'b0,
                   64'd0};
        tbl[4] = '{3'd5, 1'b0, 64'h8000_0014, 64'h8000_0020, 0, 0, 64'h8000_0020, 64'd5, 1'b0,
                   64'd0};
        tbl[5] = '{3'd6, 1'b0, 64'h8000_0024, 64'h8000_0030, 2, 1, 64'h8000_0030, 64'd6, 1'b0,
                   64'd0};
        tbl[6] = '{3'd7, 1'b0, 64'h8000_0034, 64'h8000_0500, 0, 0, 64'h8000_0034, 64'd7, 1'b0,
                   64'd0};
        tbl[7] = '{3'd4, 1'b0, 64'h8000_0038, 64'h8000_0006, 0, 0, 64'h8000_0034, 64'd7, 1'b1,
                   64'h8000_0006};

        do_reset(2);
        for (int v = 0; v < 8; v++) begin
            set_cands(tbl[v].sel, tbl[v].pcadd, tbl[v].tgt);
            do_instr(tbl[v].rq, tbl[v].rs, 0, 0, 1'b0, 32'h0000_0013 + 32'(v << 8), tbl[v].sel,
                     tbl[v].halt);
            chk("tbl.pc", pc, tbl[v].e_pc);
            chk("tbl.retired", retired, tbl[v].e_ret);
            chk("tbl.trap", 64'(trap), 64'(tbl[v].e_trap));
            chk("tbl.trap_pc", trap_pc, tbl[v].e_tpc);
        end
        idle_terminal(4);

        // ebreak with a misaligned jal target: halt wins, ex_done noise during issue is ignored.
        do_reset(2);
        set_cands(3'd1, 64'h8000_0004, 64'h8000_0102);
        do_instr(0, 0, 3, 1, 1'b1, 32'h0010_0073, 3'd1, 1'b1);
        chk("halt.halted", 64'(halted), 64'd1);
        chk("halt.pc", pc, RST_PC);
        chk("halt.retired", retired, 64'd1);
        idle_terminal(3);
        do_reset(1);
        set_cands(3'd0, 64'h8000_0004, 64'h0);
        do_instr(0, 0, 0, 0, 1'b0, 32'h0000_0013, 3'd0, 1'b0);
        chk("restart.pc", pc, 64'h8000_0004);

        // Reset while a response is arriving in FETCH_WAIT: the word must be dropped.
        do_reset(1);
        imem.if_req_ready = 1'b1;
        cycle();
        imem.if_req_ready = 1'b0;
        chk("rstwait.hs_before", hsv(), 64'd2);
        rst = 1'b1;
        imem.if_resp_valid = 1'b1;
        imem.if_resp_inst  = 32'hDEAD_BEEF;
        cycle();
        rst = 1'b0;
        imem.if_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rstwait.hs", hsv(), 64'd4);
            chk("rstwait.pc", pc, RST_PC);
            chk("rstwait.id_inst", 64'(id_inst), 64'd0);
            cycle();
        end
        set_cands(3'd0, 64'h8000_0004, 64'h0);
        do_instr(0, 0, 0, 0, 1'b0, 32'h1234_5678, 3'd0, 1'b0);

        // Randomized instruction streams.
        do_reset(1);
        for (int n = 0; n < 300; n++) begin
            if (m_halt || m_trap) do_reset(1 + int'($urandom_range(0, 1)));
            for (int k = 0; k < 8; k++) begin
                cand[k] = {$urandom, $urandom};
                if ($urandom_range(0, 9) != 0) cand[k][1:0] = 2'b00;
            end
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                     $urandom, 3'($urandom), 1'($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
